// File: rtl/free_list_pkg.sv
// free_list_pkg
//   Shared sizing, types and pointer helpers for the physical-register free
//   list. Imported by the interface, the thermometer counter and the top.
//   Optional feature macro used by the top: FL_BYPASS_EN.
package free_list_pkg;

   localparam int DP_NUM        = 2;
   localparam int RT_NUM        = 2;
   localparam int PHY_REG_NUM   = 64;
   localparam int ARCH_REG_NUM  = 32;
   localparam int FL_ENTRY_NUM  = PHY_REG_NUM - ARCH_REG_NUM;
   localparam int TAG_IDX_WIDTH = $clog2(PHY_REG_NUM);
   localparam int FL_IDX_WIDTH  = $clog2(FL_ENTRY_NUM);
   localparam int FL_CNT_WIDTH  = FL_IDX_WIDTH + 1;
   localparam int POP_CNT_W     = $clog2(DP_NUM + 1);
   localparam int PUSH_CNT_W    = $clog2(RT_NUM + 1);

   typedef logic [TAG_IDX_WIDTH-1:0] tag_t;
   typedef logic [FL_IDX_WIDTH-1:0]  idx_t;
   typedef logic [FL_CNT_WIDTH-1:0]  cnt_t;

   // Retire -> free list: freed old mappings, channel 0 in the low bits.
   typedef struct packed {
      logic [RT_NUM-1:0]                    valid;
      logic [RT_NUM-1:0][TAG_IDX_WIDTH-1:0] tag_old;
   } rob_fl_t;

   // Free list -> dispatch: per-channel availability and offered tag.
   typedef struct packed {
      logic [DP_NUM-1:0]                    avail;
      logic [DP_NUM-1:0][TAG_IDX_WIDTH-1:0] tag;
   } fl_dp_t;

   // Mod-FL_ENTRY_NUM pointer advance; n never exceeds one lap.
   function automatic idx_t idx_add(input idx_t p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= FL_ENTRY_NUM) s = s - FL_ENTRY_NUM;
      return idx_t'(s);
   endfunction

endpackage

// File: rtl/free_list_if.sv
// free_list_if
//   Bundles the dispatch (pop) and retire (push) channels of the free list.
//   master = rename/ROB side, slave = free list.
//   Handshake: there is no ready signal. fl_dp_avail_o[n] is the grant for
//   dispatch channel n; a pop on channel n is legal only while avail[n]=1.
//   dp_fl_req_i and rob_fl_valid_i are thermometer codes from channel 0 and
//   each set bit is consumed in the cycle it is presented.
interface free_list_if;
   import free_list_pkg::*;

   logic [DP_NUM-1:0]               dp_fl_req_i;
   logic [DP_NUM-1:0]               fl_dp_avail_o;
   logic [DP_NUM*TAG_IDX_WIDTH-1:0] fl_dp_tag_o;
   logic [RT_NUM-1:0]               rob_fl_valid_i;
   logic [RT_NUM*TAG_IDX_WIDTH-1:0] rob_fl_tag_i;
   logic                            exception_i;
   cnt_t                            fl_count_o;

   modport master (
      output dp_fl_req_i, rob_fl_valid_i, rob_fl_tag_i, exception_i,
      input  fl_dp_avail_o, fl_dp_tag_o, fl_count_o
   );

   modport slave (
      input  dp_fl_req_i, rob_fl_valid_i, rob_fl_tag_i, exception_i,
      output fl_dp_avail_o, fl_dp_tag_o, fl_count_o
   );

endinterface

// File: rtl/free_list_thermo_cnt.sv
// free_list_thermo_cnt
//   Counts the set bits of a request vector (used for dispatch pops and
//   retire pushes).
//   Ports: vec_i [W] request vector in, cnt_o number of set bits out.
module free_list_thermo_cnt #(
   parameter  int W  = 2,
   localparam int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  vec_i,
   output logic [CW-1:0] cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < W; i++) begin
         cnt_o = cnt_o + CW'(vec_i[i]);
      end
   end

endmodule

// File: rtl/free_list.sv
// free_list
//   Circular FIFO of free physical-register tags. Retire pushes freed old
//   tags at the tail, dispatch pops fresh tags at the head. An exception
//   rolls the head back to the (post-push) tail and refills the count.
//   Ports: clk_i, rst_i (async, active-high), fl_if (free_list_if.slave).
//   Macro FL_BYPASS_EN: same-cycle retired tags may be granted directly to
//   dispatch channels beyond the stored count.
module free_list
   import free_list_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_i,
   free_list_if.slave fl_if
);

   rob_fl_t               rob_fl;
   fl_dp_t                fl_dp;
   logic [POP_CNT_W-1:0]  pop_num;
   logic [PUSH_CNT_W-1:0] push_num;

   tag_t slot_q [FL_ENTRY_NUM];
   tag_t slot_d [FL_ENTRY_NUM];
   idx_t head_q, head_d, tail_q, tail_d;
   cnt_t count_q, count_d;
   int   count_sum;
   int   vis_cnt;

   assign rob_fl.valid   = fl_if.rob_fl_valid_i;
   assign rob_fl.tag_old = fl_if.rob_fl_tag_i;

   assign fl_if.fl_dp_avail_o = fl_dp.avail;
   assign fl_if.fl_dp_tag_o   = fl_dp.tag;
   assign fl_if.fl_count_o    = count_q;

   free_list_thermo_cnt #(.W(DP_NUM)) u_thermo_cnt_dp (
      .vec_i (fl_if.dp_fl_req_i),
      .cnt_o (pop_num)
   );

   free_list_thermo_cnt #(.W(RT_NUM)) u_thermo_cnt_rt (
      .vec_i (rob_fl.valid),
      .cnt_o (push_num)
   );

   // Tags visible to dispatch this cycle.
`ifdef FL_BYPASS_EN
   assign vis_cnt = int'(count_q) + int'(push_num);
`else
   assign vis_cnt = int'(count_q);
`endif

   always_comb begin
      int cnt, pop_n, push_n, byp, pop_arr, push_arr;
      cnt    = int'(count_q);
      pop_n  = int'(pop_num);
      push_n = int'(push_num);
      byp    = 0;
`ifdef FL_BYPASS_EN
      // Pops beyond the stored count consume this cycle's retired tags,
      // which then never reach the array.
      if (!fl_if.exception_i && pop_n > cnt)
         byp = (pop_n - cnt < push_n) ? pop_n - cnt : push_n;
`endif
      if (fl_if.exception_i) pop_arr = 0;
      else                   pop_arr = (pop_n - byp > cnt) ? cnt : pop_n - byp;
      push_arr = push_n - byp;

      slot_d = slot_q;
      for (int r = 0; r < RT_NUM; r++) begin
         if (r >= byp && r < push_n)
            slot_d[idx_add(tail_q, r - byp)] = rob_fl.tag_old[r];
      end
      tail_d    = idx_add(tail_q, push_arr);
      count_sum = cnt + push_arr - pop_arr;

      // Slots in [tail, head) belong to flushed instructions, so moving the
      // head onto the tail returns them all at once.
      if (fl_if.exception_i) begin
         head_d  = tail_d;
         count_d = cnt_t'(FL_ENTRY_NUM);
      end else begin
         head_d  = idx_add(head_q, pop_arr);
         count_d = cnt_t'(count_sum);
      end
   end

   always_comb begin
      fl_dp = '0;
      for (int n = 0; n < DP_NUM; n++) begin
         fl_dp.avail[n] = (vis_cnt >= n + 1);
         fl_dp.tag[n]   = slot_q[idx_add(head_q, n)];
`ifdef FL_BYPASS_EN
         for (int r = 0; r < RT_NUM; r++) begin
            if (n == int'(count_q) + r) fl_dp.tag[n] = rob_fl.tag_old[r];
         end
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FL_ENTRY_NUM; i++) slot_q[i] <= tag_t'(ARCH_REG_NUM + i);
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= cnt_t'(FL_ENTRY_NUM);
      end else begin
         slot_q  <= slot_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // x & (x+1) == 0 holds exactly for thermometer codes from bit 0.
   logic [DP_NUM-1:0] dp_req_inc;
   logic [RT_NUM-1:0] rt_vld_inc;
   assign dp_req_inc = fl_if.dp_fl_req_i + DP_NUM'(1);
   assign rt_vld_inc = rob_fl.valid + RT_NUM'(1);

   a_dp_thermo: assert property (@(posedge clk_i) disable iff (rst_i)
      (fl_if.dp_fl_req_i & dp_req_inc) == '0);
   a_rt_thermo: assert property (@(posedge clk_i) disable iff (rst_i)
      (rob_fl.valid & rt_vld_inc) == '0);
   a_pop_avail: assert property (@(posedge clk_i) disable iff (rst_i)
      fl_if.exception_i || int'(pop_num) <= vis_cnt);
   a_count_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
      fl_if.exception_i || count_sum <= FL_ENTRY_NUM);

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
  import free_list_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  free_list_if fl_if();

  free_list dut (
    .clk_i (clk),
    .rst_i (rst),
    .fl_if (fl_if)
  );

  // scoreboard
  int   n_cmp = 0;
  int   n_err = 0;
  logic [TAG_IDX_WIDTH-1:0] exp_q[$];
  logic [TAG_IDX_WIDTH-1:0] exp_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dp_tag(input int n);
    return 32'(fl_if.fl_dp_tag_o[n*TAG_IDX_WIDTH +: TAG_IDX_WIDTH]);
  endfunction

  // driver tasks
  task automatic drive(input logic [1:0] req, input logic [1:0] vld,
                       input int t0, input int t1, input logic exc);
    fl_if.dp_fl_req_i    = req;
    fl_if.rob_fl_valid_i = vld;
    fl_if.rob_fl_tag_i   = {TAG_IDX_WIDTH'(t1), TAG_IDX_WIDTH'(t0)};
    fl_if.exception_i    = exc;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 0, 0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    // reset image, checked while reset is still asserted
    check("rst_avail", 32'(fl_if.fl_dp_avail_o), 32'd3);
    check("rst_tag0", dp_tag(0), 32'd32);
    check("rst_tag1", dp_tag(1), 32'd33);
    check("rst_count", 32'(fl_if.fl_count_o), 32'd32);
    rst = 1'b0;

    // pop for three cycles, then assert reset between edges
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    tick(); tick(); tick();
    check("midpop_count", 32'(fl_if.fl_count_o), 32'd26);
    check("midpop_tag0", dp_tag(0), 32'd38);
    #3 rst = 1'b1;
    #1;
    check("arst_avail", 32'(fl_if.fl_dp_avail_o), 32'd3);
    check("arst_tag0", dp_tag(0), 32'd32);
    check("arst_tag1", dp_tag(1), 32'd33);
    check("arst_count", 32'(fl_if.fl_count_o), 32'd32);
    #2 rst = 1'b0;
    idle();

    // drain: two pops per cycle return 32..63 in order
    for (int t = 32; t < 64; t++) exp_q.push_back(TAG_IDX_WIDTH'(t));
    for (int i = 0; i < 16; i++) begin
      exp_tag = exp_q.pop_front();
      check("drain_tag0", dp_tag(0), 32'(exp_tag));
      exp_tag = exp_q.pop_front();
      check("drain_tag1", dp_tag(1), 32'(exp_tag));
      drive(2'b11, 2'b00, 0, 0, 1'b0);
      tick();
    end
    idle();
    check("empty_avail", 32'(fl_if.fl_dp_avail_o), 32'd0);
    check("empty_count", 32'(fl_if.fl_count_o), 32'd0);

    // retire 5,7 into the empty list
    drive(2'b00, 2'b11, 5, 7, 1'b0);
    tick();
    idle();
    check("ret_avail", 32'(fl_if.fl_dp_avail_o), 32'd3);
    check("ret_tag0", dp_tag(0), 32'd5);
    check("ret_tag1", dp_tag(1), 32'd7);
    check("ret_count", 32'(fl_if.fl_count_o), 32'd2);

    // pop one -> count 1, head holds 7
    drive(2'b01, 2'b00, 0, 0, 1'b0);
    tick();
    idle();
    check("pop1_count", 32'(fl_if.fl_count_o), 32'd1);
    check("pop1_tag0", dp_tag(0), 32'd7);

    // simultaneous pop + push 9: old head is granted, 9 appears next
    drive(2'b01, 2'b01, 9, 0, 1'b0);
    #1;
    check("pp_granted", dp_tag(0), 32'd7);
    tick();
    idle();
    check("pp_count", 32'(fl_if.fl_count_o), 32'd1);
    check("pp_next_tag0", dp_tag(0), 32'd9);
    drive(2'b01, 2'b00, 0, 0, 1'b0);
    tick();
    idle();
    check("pp_drain_count", 32'(fl_if.fl_count_o), 32'd0);
    check("pp_drain_avail", 32'(fl_if.fl_dp_avail_o), 32'd0);

    // exception rollback: pop 10, retire 1,2 then 3,4 in the exception cycle
    rst = 1'b1;
    #1 rst = 1'b0;
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    idle();
    check("ex_pre_count", 32'(fl_if.fl_count_o), 32'd22);
    check("ex_pre_tag0", dp_tag(0), 32'd42);
    drive(2'b00, 2'b11, 1, 2, 1'b0);
    tick();
    check("ex_push_count", 32'(fl_if.fl_count_o), 32'd24);
    drive(2'b11, 2'b11, 3, 4, 1'b1);
    tick();
    idle();
    check("ex_count", 32'(fl_if.fl_count_o), 32'd32);
    check("ex_avail", 32'(fl_if.fl_dp_avail_o), 32'd3);
    check("ex_tag0", dp_tag(0), 32'd36);
    check("ex_tag1", dp_tag(1), 32'd37);

    // walk the head to 31, then a two-wide pop straddles the wrap
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    for (int i = 0; i < 13; i++) tick();
    drive(2'b01, 2'b00, 0, 0, 1'b0);
    tick();
    idle();
    check("wrap_pre_count", 32'(fl_if.fl_count_o), 32'd5);
    check("wrap_tag0", dp_tag(0), 32'd63);
    check("wrap_tag1", dp_tag(1), 32'd1);
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    tick();
    idle();
    check("wrap_count", 32'(fl_if.fl_count_o), 32'd3);
    check("wrap_post_tag0", dp_tag(0), 32'd2);
    check("wrap_post_tag1", dp_tag(1), 32'd3);

    // drain to empty, then retire 12 while empty
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    tick();
    drive(2'b01, 2'b00, 0, 0, 1'b0);
    tick();
    idle();
    check("byp_pre_count", 32'(fl_if.fl_count_o), 32'd0);
`ifdef FL_BYPASS_EN
    drive(2'b01, 2'b01, 12, 0, 1'b0);
    #1;
    check("byp_avail", 32'(fl_if.fl_dp_avail_o), 32'd1);
    check("byp_tag0", dp_tag(0), 32'd12);
    tick();
    idle();
    check("byp_count", 32'(fl_if.fl_count_o), 32'd0);
`else
    drive(2'b00, 2'b01, 12, 0, 1'b0);
    #1;
    check("nobyp_avail", 32'(fl_if.fl_dp_avail_o), 32'd0);
    tick();
    idle();
    check("nobyp_next_avail", 32'(fl_if.fl_dp_avail_o), 32'd1);
    check("nobyp_tag0", dp_tag(0), 32'd12);
    check("nobyp_count", 32'(fl_if.fl_count_o), 32'd1);
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
